// File: rtl/apb4_archinfo_ext.sv
// APB4 architecture-info slave: SYS word, ID words, uptime counter with coherent 64-bit readout,
// scratch registers and a one-shot write lock. Define ARCHINFO_PSLVERR_EN for pslverr responses.
`timescale 1ns/1ps
module apb4_archinfo_ext #(
  parameter logic [31:0] SYS_RST   = 32'h0000_0000,
  parameter logic [31:0] IDL_VAL   = 32'h0000_0000,
  parameter logic [31:0] IDH_VAL   = 32'h0000_0000,
  parameter int          NUM_SCR   = 4,
  parameter int          CNT_WIDTH = 48
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  paddr,
  input  logic [2:0]  pprot,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  input  logic [3:0]  pstrb,
  output logic        pready,
  output logic [31:0] prdata,
  output logic        pslverr
);

  localparam int HI_W = CNT_WIDTH - 32;

  localparam logic [5:0] W_SYS  = 6'd0;
  localparam logic [5:0] W_IDL  = 6'd1;
  localparam logic [5:0] W_IDH  = 6'd2;
  localparam logic [5:0] W_CTRL = 6'd3;
  localparam logic [5:0] W_CNTL = 6'd4;
  localparam logic [5:0] W_CNTH = 6'd5;
  localparam logic [5:0] W_SCR  = 6'd6;

  logic [31:0]          sys_q;
  logic                 lock_q;
  logic                 cnt_en_q;
  logic [CNT_WIDTH-1:0] cnt;
  logic [HI_W-1:0]      shadow;
  logic [31:0]          scr_q [NUM_SCR];

  logic [5:0] word;
  logic [5:0] scr_off;
  logic       access;
  logic       wr;
  logic       rd;
  logic       hit_scr;
  logic       sys_we;
  logic       ctrl_we;
  logic       cnt_clr;
  logic       cntl_rd;
  logic       unused;

  assign word    = paddr[7:2];
  assign scr_off = word - W_SCR;
  assign access  = psel & penable;
  assign wr      = access & pwrite;
  assign rd      = access & ~pwrite;
  assign hit_scr = (word >= W_SCR) && (scr_off < 6'(NUM_SCR));

  // Writes to SYS/CTRL while locked are the same writes that error when pslverr is enabled.
  assign sys_we  = wr & (word == W_SYS) & ~lock_q;
  assign ctrl_we = wr & (word == W_CTRL) & ~lock_q & pstrb[0];
  assign cnt_clr = ctrl_we & pwdata[2];
  assign cntl_rd = rd & (word == W_CNTL);

  assign pready = 1'b1;
  assign unused = ^{pprot, paddr[1:0]};

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sys_q    <= SYS_RST;
      lock_q   <= 1'b0;
      cnt_en_q <= 1'b0;
      shadow   <= '0;
    end else begin
      if (sys_we) sys_q <= merge(sys_q, pwdata, pstrb);
      if (ctrl_we) begin
        lock_q   <= lock_q | pwdata[0];
        cnt_en_q <= pwdata[1];
      end
      if (cntl_rd) shadow <= cnt[CNT_WIDTH-1:32];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         cnt <= '0;
    else if (cnt_clr)  cnt <= '0;
    else if (cnt_en_q) cnt <= cnt + CNT_WIDTH'(1);
  end

  // NOTE: the scratch array is a handful of flops with a defined reset value, so it is reset
  // explicitly rather than treated as an uninitialised RAM.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_SCR; i++) scr_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SCR; i++) begin
        if (wr && hit_scr && scr_off == 6'(i)) scr_q[i] <= merge(scr_q[i], pwdata, pstrb);
      end
    end
  end

  // NOTE: prdata gets its default before any branch, so no path leaves it unassigned (no latch).
  always_comb begin
    prdata = '0;
    if (rd) begin
      case (word)
        W_SYS:   prdata = sys_q;
        W_IDL:   prdata = IDL_VAL;
        W_IDH:   prdata = IDH_VAL;
        W_CTRL:  prdata = {29'd0, 1'b0, cnt_en_q, lock_q};
        W_CNTL:  prdata = cnt[31:0];
        W_CNTH:  prdata = 32'(shadow);
        default: begin
          for (int i = 0; i < NUM_SCR; i++) begin
            if (hit_scr && scr_off == 6'(i)) prdata = scr_q[i];
          end
        end
      endcase
    end
  end

`ifdef ARCHINFO_PSLVERR_EN
  logic mapped;
  logic ro_hit;
  logic locked_hit;

  assign mapped     = (word <= W_CNTH) | hit_scr;
  assign ro_hit     = (word == W_IDL) | (word == W_IDH) | (word == W_CNTL) | (word == W_CNTH);
  assign locked_hit = lock_q & ((word == W_SYS) | (word == W_CTRL));
  assign pslverr    = access & (~mapped | (pwrite & (ro_hit | locked_hit)));
`else
  assign pslverr = 1'b0;
`endif

endmodule

// File: doc/apb4_archinfo_ext.md
Name: apb4_archinfo_ext

Overview:
- Parametrised next-generation architecture-info peripheral on the APB4 bus.
- Exposes a writable SYS word, read-only chip ID words, a free-running uptime counter with coherent 64-bit readout, and NUM_SCR general scratch registers.
- Adds a one-shot write lock to freeze SYS/CTRL after boot.
- Sits on the peripheral APB4 fabric beside other oscc-ip APB4 slaves; zero wait states.

Parameters:
- SYS_RST, 32'h0000_0000, reset value of SYS register
- IDL_VAL, 32'h0000_0000, value returned by IDL
- IDH_VAL, 32'h0000_0000, value returned by IDH
- NUM_SCR, 4, number of scratch registers; legal 1..8
- CNT_WIDTH, 48, uptime counter width; legal 33..64

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- paddr  in  8  byte address; bits [1:0] ignored
- pprot  in  3  unused
- psel  in  1  slave select
- penable  in  1  access phase
- pwrite  in  1  write when 1
- pwdata  in  32  write data
- pstrb  in  4  byte strobes
- pready  out  1  always 1
- prdata  out  32  read data, combinational in access phase
- pslverr  out  1  error response

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-high on rst_i. On reset assertion, all state loads immediately: SYS=SYS_RST, CTRL=0, counter=0, shadow=0, scratch=0.
- Reset outputs: pready=1, prdata=0, pslverr=0.
- Transfer qualification: a transfer is psel&penable. Writes commit on the clk_i edge that ends the access phase. Setup-phase cycles have no effect. prdata=0 whenever a read transfer is not active.
- Address map, word offsets:
  - 0x00 SYS: RW. Byte-wise via pstrb.
  - 0x04 IDL: RO.
  - 0x08 IDH: RO.
  - 0x0C CTRL: bit0 LOCK, bit1 CNT_EN, bit2 CNT_CLR. Bits [31:3] read 0.
  - 0x10 CNTL: RO. Returns cnt[31:0].
  - 0x14 CNTH: RO. Returns shadow, zero-extended to 32 bits.
  - 0x18+4*i SCR[i]: RW, byte-wise via pstrb.
  - All other addresses read 0.
- CTRL semantics:
  - LOCK is set-only: writing 1 sets it; writing 0 has no effect. Only rst_i clears it.
  - CNT_CLR is write-1-pulse and always reads 0.
  - CTRL uses pstrb[0] only.
- Lock: when LOCK=1, writes to SYS and CTRL are dropped, including CNT_EN and CNT_CLR. SCR writes remain allowed. A write that sets LOCK commits its other CTRL bits in the same cycle.
- Counter:
  - Increments by 1 per cycle while CNT_EN=1.
  - Wraps from 2^CNT_WIDTH-1 to 0 with no flag.
  - A CNT_CLR write forces 0 on that edge; clear has priority over increment.
- Coherent readout:
  - A read of CNTL returns cnt[31:0] as sampled in the access phase.
  - On the same edge, shadow <= cnt[CNT_WIDTH-1:32], the upper bits of the value just returned.
  - A CNTH read returns shadow unchanged. Reading CNTH without a prior CNTL returns the last latched value.
- Writes to RO or unmapped offsets are ignored.
- Simultaneous events: there is a single APB port, so only one access per cycle. Counter increment and a register write in the same cycle are independent, except for CNT_CLR priority.
- Reset mid-transfer: the transfer is abandoned. No partial write commits once rst_i is asserted.

Optional Feature:
- Macro: ARCHINFO_PSLVERR_EN.
- Defined: pslverr=1 during the access phase of any of these transfers:
  - unmapped address
  - write to IDL, IDH, CNTL or CNTH
  - write to SYS or CTRL while LOCK=1
  
  An erroring write has no side effect. An erroring read returns 0.
- Undefined: pslverr is tied to 0; the same writes are silently dropped.

Test Plan:
- Reset values: after rst_i deasserts, read 0x00/0x04/0x08 -> SYS_RST/IDL_VAL/IDH_VAL; read 0x0C, 0x10, 0x18 -> 0.
- Byte strobes: write 0x00 with 32'hA5A5_A5A5, pstrb=4'b0101 (SYS_RST=0) -> read 32'h00A5_00A5. Repeat on SCR[NUM_SCR-1] -> same.
- Lock: write CTRL=1, then SYS=32'h1234_5678, then CTRL=2 -> SYS still SYS_RST, CTRL reads 1. With ARCHINFO_PSLVERR_EN, both writes return pslverr=1. Write SCR[0]=32'hDEAD_BEEF -> reads back.
- Counter coherence: preload via enable near 32'hFFFF_FFFF carry, i.e. run CNT_EN=1 for 2^32-2 cycles (or force in sim). Read CNTL then CNTH across the carry -> {CNTH,CNTL} equals the single sampled value, not a torn mix.
- Clear/wrap: CNT_WIDTH=33, cnt=2^33-1, CNT_EN=1 -> next cycle reads 0. Write CTRL=3'b110 during counting -> CNTL reads small value (<=3), CNTH=0.
- Reset mid-operation: assert rst_i during the access phase of a SYS write -> SYS=SYS_RST, LOCK=0, counter=0 after release.
